// File: rtl/uart_rx_host.sv
// 16x-oversampling UART receiver with start-glitch rejection, optional parity,
// and a one-entry valid/ready output buffer with sticky overrun.
//   state  | meaning
//   IDLE   | line idle, tick generator held
//   START  | waiting for mid start bit to confirm
//   DATA   | shifting data bits in LSB first
//   PARITY | sampling parity bit
//   STOP   | sampling stop bit, deliver or flag framing error
//   BREAK  | line held low after bad stop, wait for release
module uart_rx_host #(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic          ODD       = (PARITY_MODE == 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_rx_meta, r_rxs;
    logic [TW-1:0]          r_tick_cnt;
    logic [3:0]             r_smp_cnt;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid, r_perr, r_frame_err, r_overrun;
    logic                   w_tick, w_half, w_mid, w_done, w_stop_bad;

    assign w_tick     = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_half     = w_tick && (r_smp_cnt == 4'd7);
    assign w_mid      = w_tick && (r_smp_cnt == 4'd15);
    assign w_done     = (r_state == S_STOP) && w_mid && r_rxs;
    assign w_stop_bad = (r_state == S_STOP) && w_mid && !r_rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!r_rxs) w_state_nxt = S_START;
            S_START:  if (w_half) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
            S_DATA:   if (w_mid && (r_bit_idx == BIT_LAST))
                          w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_mid) w_state_nxt = S_STOP;
            S_STOP:   if (w_mid) w_state_nxt = r_rxs ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rxs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Sample counter restarts at mid start bit so every later sample lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_smp_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE || w_tick) r_tick_cnt <= '0;
            else                             r_tick_cnt <= r_tick_cnt + TW'(1);

            if (r_state == S_IDLE)                      r_smp_cnt <= '0;
            else if (w_half && (r_state == S_START))    r_smp_cnt <= '0;
            else if (w_tick)                            r_smp_cnt <= r_smp_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    r_bit_idx <= '0;
                    r_par_bad <= 1'b0;
                end
                S_DATA: if (w_mid) begin
                    r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
                    r_bit_idx <= r_bit_idx + BW'(1);
                end
                S_PARITY: if (w_mid) r_par_bad <= (((^r_shift) ^ r_rxs) != ODD);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            if (w_done) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_perr  <= r_par_bad;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_host.sv
// Directed bench for uart_rx_host: 8N-odd instance for framing/parity/overrun/
// break/reset cases, 7-bit no-parity instance for back-to-back delivery.
module tb_uart_rx_host;

    logic clk = 1'b0, rst = 1'b1;
    logic rx = 1'b1, rx_ready = 1'b0;
    logic rx7 = 1'b1, rx_ready7 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun;
    logic [6:0] rx_data7;
    logic       rx_valid7, parity_err7, frame_err7, overrun7;

    always #5 clk = ~clk;

    uart_rx_host #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000),
                   .DATA_BITS(8), .PARITY_MODE(1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun)
    );

    uart_rx_host #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000),
                   .DATA_BITS(7), .PARITY_MODE(0)) dut7 (
        .clk(clk), .rst(rst), .rx(rx7), .rx_ready(rx_ready7),
        .rx_data(rx_data7), .rx_valid(rx_valid7), .parity_err(parity_err7),
        .frame_err(frame_err7), .overrun(overrun7)
    );

    int errors = 0, checks = 0;
    int cyc = 0, rise_cnt = 0, rise_cyc = 0, vcyc = 0, fe_cnt = 0;
    int fall7 = 0, fe7_cnt = 0;
    logic prev_v = 1'b0, prev_v7 = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid) begin
            vcyc++;
            cap_data = rx_data;
            cap_perr = parity_err;
        end
        if (rx_valid && !prev_v) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (prev_v7 && !rx_valid7) fall7++;
        if (frame_err7) fe7_cnt++;
        prev_v  = rx_valid;
        prev_v7 = rx_valid7;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par);
        rx = 1'b0; wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; wait_clk(16);
        end
        rx = par;  wait_clk(16);
        rx = 1'b1; wait_clk(16);
    endtask

    task automatic send7(input logic [6:0] d);
        rx7 = 1'b0; wait_clk(16);
        for (int i = 0; i < 7; i++) begin
            rx7 = d[i]; wait_clk(16);
        end
        rx7 = 1'b1; wait_clk(16);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " rx_data"},    int'(rx_data),    0);
        check({tag, " rx_valid"},   int'(rx_valid),   0);
        check({tag, " parity_err"}, int'(parity_err), 0);
        check({tag, " frame_err"},  int'(frame_err),  0);
        check({tag, " overrun"},    int'(overrun),    0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[7];
    // start edge -> IDLE exit is 3 clk (2 sync flops + IDLE decision), then 8 + 16*10 ticks
    localparam int LAT = 3 + 8 + 16 * (8 + 1 + 1);

    initial begin
        int s_rise, s_v, s_fe, s_fall, s_fe7, c0;

        vecs[0] = '{8'h55, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b0};

        wait_clk(3);
        check_reset_vals("reset");
        check("reset rx_valid7", int'(rx_valid7), 0);
        rst = 1'b0;
        wait_clk(4);

        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            s_rise = rise_cnt; s_v = vcyc; s_fe = fe_cnt; c0 = cyc;
            send_frame(vecs[i].data, vecs[i].par);
            wait_clk(4);
            check($sformatf("vec%0d data", i), int'(cap_data), int'(vecs[i].data));
            check($sformatf("vec%0d parity_err", i), int'(cap_perr), int'(vecs[i].exp_perr));
            check($sformatf("vec%0d valid_cycles", i), vcyc - s_v, 1);
            check($sformatf("vec%0d frame_err", i), fe_cnt - s_fe, 0);
            check_range($sformatf("vec%0d latency", i), rise_cyc - c0, LAT - 1, LAT + 1);
        end
        check("no overrun after vectors", int'(overrun), 0);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_clk(4);
        check("ovr first valid", int'(rx_valid), 1);
        check("ovr first data", int'(rx_data), 8'h11);
        check("ovr before drop", int'(overrun), 0);
        send_frame(8'h22, 1'b1);
        wait_clk(4);
        check("ovr data held", int'(rx_data), 8'h11);
        check("ovr flag", int'(overrun), 1);
        check("ovr still valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("consume clears valid", int'(rx_valid), 0);
        check("overrun sticky", int'(overrun), 1);
        check("data after consume", int'(rx_data), 8'h11);

        s_fe = fe_cnt; s_rise = rise_cnt;
        rx = 1'b0;
        wait_clk(1600);
        rx = 1'b1;
        wait_clk(32);
        check("break frame_err pulses", fe_cnt - s_fe, 1);
        check("break no valid", rise_cnt - s_rise, 0);
        rx_ready = 1'b1;
        s_rise = rise_cnt;
        send_frame(8'h3C, 1'b1);
        wait_clk(4);
        check("after break data", int'(cap_data), 8'h3C);
        check("after break perr", int'(cap_perr), 0);
        check("after break valid", rise_cnt - s_rise, 1);

        s_fe = fe_cnt; s_rise = rise_cnt;
        rx = 1'b0;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(48);
        check("glitch no valid", rise_cnt - s_rise, 0);
        check("glitch no frame_err", fe_cnt - s_fe, 0);

        rx = 1'b0; wait_clk(16);
        rx = 1'b1; wait_clk(16 * 4 + 8);
        rst = 1'b1;
        wait_clk(2);
        check_reset_vals("midframe rst");
        rst = 1'b0;
        wait_clk(64);
        s_fe = fe_cnt; s_rise = rise_cnt;
        send_frame(8'h81, 1'b1);
        wait_clk(4);
        check("post rst data", int'(cap_data), 8'h81);
        check("post rst perr", int'(cap_perr), 0);
        check("post rst valid", rise_cnt - s_rise, 1);
        check("post rst frame_err", fe_cnt - s_fe, 0);
        check("post rst overrun", int'(overrun), 0);

        s_fall = fall7; s_fe7 = fe7_cnt;
        rx_ready7 = 1'b0;
        fork
            begin
                send7(7'h7F);
                send7(7'h01);
            end
            begin
                // second frame completes in the cycle ending at edge 283
                repeat (282) @(posedge clk);
                #1 rx_ready7 = 1'b1;
                @(posedge clk);
                #1 rx_ready7 = 1'b0;
            end
            begin
                wait_clk(200);
                check("b2b first valid", int'(rx_valid7), 1);
                check("b2b first data", int'(rx_data7), 7'h7F);
            end
        join
        wait_clk(4);
        check("b2b second data", int'(rx_data7), 7'h01);
        check("b2b still valid", int'(rx_valid7), 1);
        check("b2b valid never dropped", fall7 - s_fall, 0);
        check("b2b overrun", int'(overrun7), 0);
        check("b2b frame_err", fe7_cnt - s_fe7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
